hovalaag_input_fifo: RTL and testbench

- Dual input-stream buffer that sits directly upstream of the Hovalaag CPU core and drives its IN1/IN2 ports.
- The host or test harness pushes 12-bit words into two independent show-ahead FIFOs, one per input channel.
- The CPU consumes words through the IN1_adv/IN2_adv strobes.
- Underflow and overflow are reported as sticky flags so a stalled or misbehaving program is detectable.

---
 rtl/hovalaag_input_fifo.sv | 133 +++++++++++++
 tb/tb_hovalaag_input_fifo.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hovalaag_input_fifo.sv
// hovalaag_input_fifo
// Dual show-ahead input buffer that feeds the IN1/IN2 ports of the Hovalaag
// CPU core. A host pushes WIDTH-bit words into one of two independent FIFOs.
// The CPU consumes them through the IN1_adv/IN2_adv strobes, which are
// qualified by the core's clk_en. Underflow and overflow are sticky per
// channel, so a stalled or misbehaving program can be spotted afterwards.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   clk_en              CPU clock enable; gates consumption only
//   flush               synchronous clear of both FIFOs and all flags
//   wr_en, wr_sel       host write strobe; channel select (0 = ch1, 1 = ch2)
//   wr_data             word to push
//   wr_ready            selected channel is not full (combinational)
//   IN1, IN2            head word of each channel, 0 when empty
//   IN1_adv, IN2_adv    CPU consume strobes
//   in1_count/in2_count occupancy of each channel
//   in1_empty/in2_empty occupancy is zero
//   underflow/overflow  sticky error flags, bit0 = ch1, bit1 = ch2
module hovalaag_input_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic                  wr_sel,
    input  logic [WIDTH-1:0]      wr_data,
    output logic                  wr_ready,
    output logic [WIDTH-1:0]      IN1,
    input  logic                  IN1_adv,
    output logic [WIDTH-1:0]      IN2,
    input  logic                  IN2_adv,
    output logic [DEPTH_LOG2:0]   in1_count,
    output logic [DEPTH_LOG2:0]   in2_count,
    output logic                  in1_empty,
    output logic                  in2_empty,
    output logic [1:0]            underflow,
    output logic [1:0]            overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    // Per-channel views of the shared controls, index 0 = ch1, 1 = ch2.
    logic [1:0]                   sel_hit;
    logic [1:0]                   adv;
    logic [1:0][WIDTH-1:0]        head;
    logic [1:0][DEPTH_LOG2:0]     count;
    logic [1:0]                   full;

    assign sel_hit = {wr_sel, ~wr_sel};
    assign adv     = {IN2_adv, IN1_adv};

    for (genvar c = 0; c < 2; c++) begin : g_chan
        logic [WIDTH-1:0]      mem [DEPTH];
        logic [DEPTH_LOG2-1:0] wptr;
        logic [DEPTH_LOG2-1:0] rptr;
        logic [DEPTH_LOG2:0]   cnt;
        logic                  ovf;
        logic                  unf;
        logic                  push_req;
        logic                  pop_req;
        logic                  push;
        logic                  pop;
        logic                  is_empty;
        logic                  is_full;

        // Fullness and emptiness come from the pre-edge count, so a push
        // into a full FIFO is refused even if a pop happens on the same edge,
        // and a pop of an empty FIFO is an underflow even alongside a push.
        assign is_empty = (cnt == '0);
        assign is_full  = (cnt == FULL_COUNT);
        assign push_req = wr_en & sel_hit[c];
        assign pop_req  = clk_en & adv[c];
        assign push     = push_req & ~is_full & ~rst & ~flush;
        assign pop      = pop_req & ~is_empty & ~rst & ~flush;

        // Storage has no reset; stale entries are never visible because the
        // head is masked to 0 whenever the count is zero.
        always_ff @(posedge clk) begin
            if (push) begin
                mem[wptr] <= wr_data;
            end
        end

        // Pointers, occupancy and sticky flags; rst and flush both clear all.
        always_ff @(posedge clk) begin
            if (rst || flush) begin
                wptr <= '0;
                rptr <= '0;
                cnt  <= '0;
                ovf  <= 1'b0;
                unf  <= 1'b0;
            end else begin
                if (push) begin
                    wptr <= wptr + 1'b1;
                end
                if (pop) begin
                    rptr <= rptr + 1'b1;
                end
                if (push && !pop) begin
                    cnt <= cnt + 1'b1;
                end else if (pop && !push) begin
                    cnt <= cnt - 1'b1;
                end
                if (push_req && is_full) begin
                    ovf <= 1'b1;
                end
                if (pop_req && is_empty) begin
                    unf <= 1'b1;
                end
            end
        end

        assign head[c]      = is_empty ? '0 : mem[rptr];
        assign count[c]     = cnt;
        assign full[c]      = is_full;
        assign overflow[c]  = ovf;
        assign underflow[c] = unf;
    end

    assign IN1       = head[0];
    assign IN2       = head[1];
    assign in1_count = count[0];
    assign in2_count = count[1];
    assign in1_empty = (count[0] == '0);
    assign in2_empty = (count[1] == '0);
    assign wr_ready  = wr_sel ? ~full[1] : ~full[0];

endmodule

// File: tb/tb_hovalaag_input_fifo.sv
// Testbench for hovalaag_input_fifo: a queue-based reference model tracks both
// channels and a negedge compare process checks every output each cycle, while
// directed sequences add hand-computed literal checks.
module tb_hovalaag_input_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        flush;
    logic        wr_en;
    logic        wr_sel;
    logic [11:0] wr_data;
    logic        wr_ready;
    logic [11:0] IN1;
    logic        IN1_adv;
    logic [11:0] IN2;
    logic        IN2_adv;
    logic [4:0]  in1_count;
    logic [4:0]  in2_count;
    logic        in1_empty;
    logic        in2_empty;
    logic [1:0]  underflow;
    logic [1:0]  overflow;

    int tests_run = 0;
    int tests_failed = 0;
    bit check_en = 1'b0;

    // Reference model state
    logic [11:0] q1[$];
    logic [11:0] q2[$];
    logic [1:0]  m_unf = 2'b00;
    logic [1:0]  m_ovf = 2'b00;
    int          s1;
    int          s2;

    hovalaag_input_fifo #(.DEPTH_LOG2(4), .WIDTH(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_en    (clk_en),
        .flush     (flush),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .IN1       (IN1),
        .IN1_adv   (IN1_adv),
        .IN2       (IN2),
        .IN2_adv   (IN2_adv),
        .in1_count (in1_count),
        .in2_count (in2_count),
        .in1_empty (in1_empty),
        .in2_empty (in2_empty),
        .underflow (underflow),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, return 1 time unit later.
    task automatic applyStimulus(input logic we, input logic sel,
                                 input logic [11:0] data, input logic en,
                                 input logic a1, input logic a2,
                                 input logic fl);
        wr_en   = we;
        wr_sel  = sel;
        wr_data = data;
        clk_en  = en;
        IN1_adv = a1;
        IN2_adv = a2;
        flush   = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, wr_sel, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Model: fullness/emptiness judged on sizes before the edge; a refused
    // push or an empty pop only raises the sticky flag.
    initial begin
        forever begin
            @(posedge clk);
            if (rst || flush) begin
                q1.delete();
                q2.delete();
                m_unf = 2'b00;
                m_ovf = 2'b00;
            end else begin
                s1 = q1.size();
                s2 = q2.size();
                if (wr_en && !wr_sel) begin
                    if (s1 == 16) m_ovf[0] = 1'b1;
                    else q1.push_back(wr_data);
                end
                if (wr_en && wr_sel) begin
                    if (s2 == 16) m_ovf[1] = 1'b1;
                    else q2.push_back(wr_data);
                end
                if (clk_en && IN1_adv) begin
                    if (s1 == 0) m_unf[0] = 1'b1;
                    else void'(q1.pop_front());
                end
                if (clk_en && IN2_adv) begin
                    if (s2 == 0) m_unf[1] = 1'b1;
                    else void'(q2.pop_front());
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("IN1", 32'(IN1), 32'(q1.size() != 0 ? q1[0] : 12'h000));
            checkOutput("IN2", 32'(IN2), 32'(q2.size() != 0 ? q2[0] : 12'h000));
            checkOutput("in1_count", 32'(in1_count), 32'(q1.size()));
            checkOutput("in2_count", 32'(in2_count), 32'(q2.size()));
            checkOutput("in1_empty", 32'(in1_empty), 32'(q1.size() == 0));
            checkOutput("in2_empty", 32'(in2_empty), 32'(q2.size() == 0));
            checkOutput("wr_ready", 32'(wr_ready),
                        32'((wr_sel ? q2.size() : q1.size()) != 16));
            checkOutput("underflow", 32'(underflow), 32'(m_unf));
            checkOutput("overflow", 32'(overflow), 32'(m_ovf));
        end
    end

    initial begin
        rst = 1'b1;
        wr_en = 1'b0; wr_sel = 1'b0; wr_data = '0;
        clk_en = 1'b0; IN1_adv = 1'b0; IN2_adv = 1'b0; flush = 1'b0;
        @(posedge clk);
        #1;
        check_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        checkOutput("rst_in1_empty", 32'(in1_empty), 32'd1);
        checkOutput("rst_in2_empty", 32'(in2_empty), 32'd1);
        checkOutput("rst_wr_ready", 32'(wr_ready), 32'd1);
        checkOutput("rst_IN1", 32'(IN1), 32'h0);
        checkOutput("rst_flags", 32'({underflow, overflow}), 32'h0);

        // Two pushes to ch1 with clk_en low; IN1_adv is ignored without clk_en
        applyStimulus(1'b1, 1'b0, 12'h123, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 12'h456, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        checkOutput("push2_count", 32'(in1_count), 32'd2);
        checkOutput("push2_IN1", 32'(IN1), 32'h123);
        checkOutput("push2_IN2", 32'(IN2), 32'h0);
        checkOutput("push2_in2_empty", 32'(in2_empty), 32'd1);

        // Two pops drain ch1
        applyStimulus(1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("pop1_IN1", 32'(IN1), 32'h456);
        checkOutput("pop1_count", 32'(in1_count), 32'd1);
        applyStimulus(1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("pop2_IN1", 32'(IN1), 32'h0);
        checkOutput("pop2_empty", 32'(in1_empty), 32'd1);
        checkOutput("pop2_underflow", 32'(underflow), 32'b00);

        // Pop of empty ch2: flagged only when clk_en is high
        applyStimulus(1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("unf2_flag", 32'(underflow), 32'b10);
        checkOutput("unf2_count", 32'(in2_count), 32'd0);
        applyStimulus(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("unf2_gated", 32'(underflow), 32'b00);

        // 17 pushes to ch2: last one overflows
        for (int i = 1; i <= 17; i++) begin
            applyStimulus(1'b1, 1'b1, 12'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("full2_count", 32'(in2_count), 32'd16);
        checkOutput("full2_wr_ready", 32'(wr_ready), 32'd0);
        checkOutput("full2_overflow", 32'(overflow), 32'b10);
        for (int i = 1; i <= 16; i++) begin
            checkOutput("wrap_order", 32'(IN2), 32'(i));
            applyStimulus(1'b0, 1'b1, 12'h000, 1'b1, 1'b0, 1'b1, 1'b0);
        end
        checkOutput("drain2_empty", 32'(in2_empty), 32'd1);

        // Full ch2 with push + pop on the same edge: push refused
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b1, 12'h200 + 12'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 12'h2FF, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("fullpp_count", 32'(in2_count), 32'd15);
        checkOutput("fullpp_IN2", 32'(IN2), 32'h201);
        applyStimulus(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1);

        // Empty ch1 with push + pop: underflow, pushed word stays
        applyStimulus(1'b1, 1'b0, 12'h777, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("emptypp_count", 32'(in1_count), 32'd1);
        checkOutput("emptypp_IN1", 32'(IN1), 32'h777);
        checkOutput("emptypp_unf", 32'(underflow), 32'b01);
        applyStimulus(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1);

        // Three entries, then 20 cycles of simultaneous push and pop
        applyStimulus(1'b1, 1'b0, 12'hA01, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 12'hA02, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 12'hA03, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 12'hABC, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("pp_count", 32'(in1_count), 32'd3);
        checkOutput("pp_head", 32'(IN1), 32'hA02);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b0, 12'hB00 + 12'(i), 1'b1, 1'b1, 1'b0, 1'b0);
        end
        checkOutput("pp20_count", 32'(in1_count), 32'd3);
        checkOutput("pp20_head", 32'(IN1), 32'hB11);

        // Flush beats a concurrent push
        applyStimulus(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 12'h300 + 12'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("pre_flush_unf", 32'(underflow), 32'b10);
        applyStimulus(1'b1, 1'b0, 12'h3FF, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("flush_count", 32'(in1_count), 32'd0);
        checkOutput("flush_flags", 32'({underflow, overflow}), 32'h0);
        checkOutput("flush_IN1", 32'(IN1), 32'h0);

        // Reset mid-stream beats a concurrent push and pop
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 12'h400 + 12'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 12'h4FF, 1'b1, 1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        checkOutput("rst_mid_count", 32'(in1_count), 32'd0);
        checkOutput("rst_mid_flags", 32'({underflow, overflow}), 32'h0);
        checkOutput("rst_mid_IN1", 32'(IN1), 32'h0);
        idle();
        idle();

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
